// File: rtl/mcu_gpio_pkg.sv
// Shared bit positions, FSM states and response layout for the MCU GPIO register bridge.
package mcu_gpio_pkg;

  localparam int kReqToggleBit = 31;
  localparam int kWrBit        = 30;
  localparam int kAddrLsb      = 16;
  localparam int kDataLsb      = 0;
  localparam int kAckToggleBit = 31;
  localparam int kErrBit       = 30;
  localparam int kCountLsb     = 22;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESPOND = 2'd3
  } bridge_state_t;

  typedef struct packed {
    logic        ack_toggle;
    logic        err;
    logic [7:0]  count;
    logic [15:0] data;
  } resp_word_t;

  // Places the response fields into the 32-bit GPIO input word; unused bits read as zero.
  function automatic logic [31:0] pack_resp(input resp_word_t r);
    logic [31:0] w;
    w                  = 32'd0;
    w[kAckToggleBit]   = r.ack_toggle;
    w[kErrBit]         = r.err;
    w[kCountLsb +: 8]  = r.count;
    w[15:0]            = r.data;
    return w;
  endfunction

endpackage

// File: rtl/mcu_toggle_edge.sv
// Registers the MCU command word and flags a pending command when ReqToggle differs from the last
// serviced value. Priming waits for the first post-reset sample so a held toggle is never a request.
module mcu_toggle_edge
  import mcu_gpio_pkg::*;
(
  input  logic        SysClk,
  input  logic        aSysRst,
  input  logic [31:0] sMcuOutputControl,
  input  logic        accept_s,
  output logic [31:0] cmd_q_r,
  output logic        pending_s
);

  logic sample_valid_r;
  logic primed_r;
  logic prev_toggle_r;

  // Input register, priming and tracking of the last accepted toggle
  always_ff @(posedge SysClk or posedge aSysRst) begin
    if (aSysRst) begin
      cmd_q_r        <= 32'd0;
      sample_valid_r <= 1'b0;
      primed_r       <= 1'b0;
      prev_toggle_r  <= 1'b0;
    end else begin
      cmd_q_r        <= sMcuOutputControl;
      sample_valid_r <= 1'b1;
      if (sample_valid_r && !primed_r) begin
        prev_toggle_r <= cmd_q_r[kReqToggleBit];
        primed_r      <= 1'b1;
      end else if (accept_s) begin
        prev_toggle_r <= cmd_q_r[kReqToggleBit];
      end
    end
  end

  assign pending_s = primed_r && (cmd_q_r[kReqToggleBit] != prev_toggle_r);

endmodule

// File: rtl/mcu_gpio_reg_bridge.sv
// Bridges toggle-handshaked MCU GPIO commands to single-cycle register-bus strobes and responses.
// Optional read-response timeout: define MCU_REG_TIMEOUT_EN.
module mcu_gpio_reg_bridge
  import mcu_gpio_pkg::*;
#(
  parameter int kAddrWidth     = 8,
  parameter int kDataWidth     = 16,
  parameter int kTimeoutCycles = 1024
) (
  input  logic                  SysClk,
  input  logic                  aSysRst,
  input  logic [31:0]           sMcuOutputControl,
  output logic [31:0]           sMcuInputControl,
  output logic [kAddrWidth-1:0] sRegAddr,
  output logic                  sRegWrEn,
  output logic [kDataWidth-1:0] sRegWrData,
  output logic                  sRegRdEn,
  input  logic [kDataWidth-1:0] sRegRdData,
  input  logic                  sRegRdValid,
  output logic                  sBusy
);

  logic [31:0]           cmd_q_s;
  logic                  pending_s;
  logic                  accept_s;
  logic                  rd_done_s;
  logic                  timeout_s;
  logic                  unused_cmd_s;
  bridge_state_t         state_r;
  bridge_state_t         state_next_s;
  logic                  wr_r;
  logic [kAddrWidth-1:0] addr_r;
  logic [kDataWidth-1:0] wr_data_r;
  logic [kDataWidth-1:0] rd_data_r;
  logic [15:0]           rd_data_ext_s;
  logic                  err_r;
  logic                  wr_en_r;
  logic                  rd_en_r;
  logic                  busy_r;
  resp_word_t            resp_r;

  mcu_toggle_edge u_toggle_edge (
    .SysClk            (SysClk),
    .aSysRst           (aSysRst),
    .sMcuOutputControl (sMcuOutputControl),
    .accept_s          (accept_s),
    .cmd_q_r           (cmd_q_s),
    .pending_s         (pending_s)
  );

  // Address bits above kAddrWidth and data bits above kDataWidth are don't-care.
  assign unused_cmd_s = ^cmd_q_s;

`ifdef MCU_REG_TIMEOUT_EN
  localparam int kTmoWidth = (kTimeoutCycles > 1) ? $clog2(kTimeoutCycles) : 1;
  logic [kTmoWidth-1:0] tmo_cnt_r;

  // Read-response watchdog, held clear outside WAIT_RD so it restarts on every entry
  always_ff @(posedge SysClk or posedge aSysRst) begin
    if (aSysRst) begin
      tmo_cnt_r <= {kTmoWidth{1'b0}};
    end else if (state_r == WAIT_RD) begin
      tmo_cnt_r <= tmo_cnt_r + kTmoWidth'(1);
    end else begin
      tmo_cnt_r <= {kTmoWidth{1'b0}};
    end
  end

  assign timeout_s = (state_r == WAIT_RD) && (tmo_cnt_r == kTmoWidth'(kTimeoutCycles - 1));
`else
  logic [31:0] unused_tmo_s;
  assign unused_tmo_s = 32'(kTimeoutCycles);
  assign timeout_s    = 1'b0;
`endif

  // Next-state decode; valid read data takes priority over a simultaneous timeout
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    rd_done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (pending_s) begin
          accept_s     = 1'b1;
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (wr_r) begin
          state_next_s = RESPOND;
        end else begin
          state_next_s = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (sRegRdValid) begin
          rd_done_s    = 1'b1;
          state_next_s = RESPOND;
        end else if (timeout_s) begin
          state_next_s = RESPOND;
        end else begin
          state_next_s = WAIT_RD;
        end
      end
      RESPOND: state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Zero-extend read data into the 16-bit response field
  always_comb begin
    rd_data_ext_s                   = 16'd0;
    rd_data_ext_s[kDataWidth-1:0]   = rd_data_r;
  end

  // FSM state, command latch, bus strobes and response word
  always_ff @(posedge SysClk or posedge aSysRst) begin
    if (aSysRst) begin
      state_r   <= IDLE;
      busy_r    <= 1'b0;
      wr_r      <= 1'b0;
      addr_r    <= {kAddrWidth{1'b0}};
      wr_data_r <= {kDataWidth{1'b0}};
      rd_data_r <= {kDataWidth{1'b0}};
      err_r     <= 1'b0;
      wr_en_r   <= 1'b0;
      rd_en_r   <= 1'b0;
      resp_r    <= '{ack_toggle: 1'b0, err: 1'b0, count: 8'd0, data: 16'd0};
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
      wr_en_r <= (state_r == ISSUE) && wr_r;
      rd_en_r <= (state_r == ISSUE) && !wr_r;
      if (accept_s) begin
        wr_r      <= cmd_q_s[kWrBit];
        addr_r    <= cmd_q_s[kAddrLsb +: kAddrWidth];
        wr_data_r <= cmd_q_s[kDataLsb +: kDataWidth];
        err_r     <= 1'b0;
      end
      if (rd_done_s) begin
        rd_data_r <= sRegRdData;
        err_r     <= 1'b0;
      end else if (timeout_s) begin
        rd_data_r <= {kDataWidth{1'b1}};
        err_r     <= 1'b1;
      end
      if (state_r == RESPOND) begin
        resp_r.ack_toggle <= ~resp_r.ack_toggle;
        resp_r.err        <= err_r;
        resp_r.count      <= resp_r.count + 8'd1;
        if (!wr_r) begin
          resp_r.data <= rd_data_ext_s;
        end
      end
    end
  end

  assign sMcuInputControl = pack_resp(resp_r);
  assign sRegAddr         = addr_r;
  assign sRegWrEn         = wr_en_r;
  assign sRegWrData       = wr_data_r;
  assign sRegRdEn         = rd_en_r;
  assign sBusy            = busy_r;

endmodule

// File: tb/tb_mcu_gpio_reg_bridge.sv
// Directed self-checking bench for mcu_gpio_reg_bridge; timeout scenario runs when
// MCU_REG_TIMEOUT_EN is defined (bridge built with a 16-cycle timeout).
`timescale 1ns/1ps
module tb_mcu_gpio_reg_bridge;

`ifdef MCU_REG_TIMEOUT_EN
  localparam int kTmo = 16;
`else
  localparam int kTmo = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmd;
  logic [31:0] resp;
  logic [7:0]  addr;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_cnt   = 0;
  int          rd_cnt   = 0;
  int          wr0;
  int          rd0;
  logic [7:0]  last_wr_addr = 8'd0;
  logic [15:0] last_wr_data = 16'd0;
  logic        tog     = 1'b0;
  logic        exp_ack = 1'b0;
  logic [7:0]  exp_cnt = 8'd0;

  always #5 clk = ~clk;

  mcu_gpio_reg_bridge #(.kAddrWidth(8), .kDataWidth(16), .kTimeoutCycles(kTmo)) dut (
    .SysClk            (clk),
    .aSysRst           (rst),
    .sMcuOutputControl (cmd),
    .sMcuInputControl  (resp),
    .sRegAddr          (addr),
    .sRegWrEn          (wr_en),
    .sRegWrData        (wr_data),
    .sRegRdEn          (rd_en),
    .sRegRdData        (rd_data),
    .sRegRdValid       (rd_valid),
    .sBusy             (busy)
  );

  // Strobe monitor, sampled shortly after each rising edge
  always @(posedge clk) begin
    #2;
    if (wr_en === 1'b1) begin
      wr_cnt       = wr_cnt + 1;
      last_wr_addr = addr;
      last_wr_data = wr_data;
    end
    if (rd_en === 1'b1) rd_cnt = rd_cnt + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] resp_word(input logic ack, input logic err,
                                            input logic [7:0] cnt, input logic [15:0] d);
    return {ack, err, cnt, 6'd0, d};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_cmd(input logic wr, input logic [7:0] a, input logic [15:0] d);
    tog = ~tog;
    cmd = {tog, wr, 6'd0, a, d};
  endtask

  task automatic wait_ack(input string tag, input int budget);
    int k;
    k = 0;
    while (resp[31] === exp_ack && k < budget) begin
      @(negedge clk);
      k++;
    end
    exp_ack = ~exp_ack;
    exp_cnt = exp_cnt + 8'd1;
    check_value(tag, {31'd0, resp[31]}, {31'd0, exp_ack});
  endtask

  task automatic do_write(input string tag, input logic [7:0] a, input logic [15:0] d);
    drive_cmd(1'b1, a, d);
    wait_ack(tag, 12);
  endtask

  task automatic do_read(input string tag, input logic [7:0] a, input logic [15:0] d, input int dly);
    drive_cmd(1'b0, a, 16'd0);
    cycles(3 + dly);
    rd_valid = 1'b1;
    rd_data  = d;
    cycles(1);
    rd_valid = 1'b0;
    wait_ack(tag, 12);
  endtask

  initial begin
    rst = 1'b1; cmd = 32'd0; rd_valid = 1'b0; rd_data = 16'd0;
    cycles(3);
    check_value("rst_resp", resp, 32'd0);
    check_value("rst_outs", {addr, wr_data, wr_en, rd_en, busy}, 32'd0);
    rst = 1'b0;
    cycles(3);

    // Write: strobe three cycles after the toggle, ack one cycle later
    drive_cmd(1'b1, 8'h12, 16'h00AB);
    cycles(2);
    check_value("wr_no_early_strobe", {31'd0, wr_en}, 32'd0);
    check_value("wr_busy", {31'd0, busy}, 32'd1);
    cycles(1);
    check_value("wr_strobe", {wr_en, rd_en, addr, wr_data}, {1'b1, 1'b0, 8'h12, 16'h00AB, 6'd0} >> 6);
    check_value("wr_ack_not_yet", {31'd0, resp[31]}, 32'd0);
    cycles(1);
    check_value("wr_strobe_end", {31'd0, wr_en}, 32'd0);
    check_value("wr_resp", resp, resp_word(1'b1, 1'b0, 8'd1, 16'd0));
    exp_ack = 1'b1; exp_cnt = 8'd1;
    check_value("wr_count_pulses", wr_cnt, 1);

    // Read: data returned three cycles after the read strobe
    drive_cmd(1'b0, 8'h34, 16'd0);
    check_value("rd_cmd_word", cmd, 32'h0034_0000);
    cycles(3);
    check_value("rd_strobe", {rd_en, wr_en, addr}, {1'b1, 1'b0, 8'h34} & 10'h3FF);
    cycles(3);
    rd_valid = 1'b1; rd_data = 16'h5A5A;
    cycles(1);
    rd_valid = 1'b0; rd_data = 16'h0000;
    check_value("rd_ack_not_yet", {31'd0, resp[31]}, 32'd1);
    cycles(1);
    check_value("rd_resp", resp, resp_word(1'b0, 1'b0, 8'd2, 16'h5A5A));
    check_value("rd_idle", {31'd0, busy}, 32'd0);
    exp_ack = 1'b0; exp_cnt = 8'd2;

    // Read-valid while idle is ignored
    rd_valid = 1'b1; rd_data = 16'h7777;
    cycles(1);
    rd_valid = 1'b0;
    cycles(4);
    check_value("stray_valid", resp, resp_word(exp_ack, 1'b0, exp_cnt, 16'h5A5A));

`ifdef MCU_REG_TIMEOUT_EN
    // Timeout: 16 cycles in WAIT_RD, then Err with all-ones data
    drive_cmd(1'b0, 8'h55, 16'd0);
    cycles(19);
    check_value("tmo_not_yet", {31'd0, resp[31]}, {31'd0, exp_ack});
    cycles(1);
    check_value("tmo_resp", resp, resp_word(~exp_ack, 1'b1, exp_cnt + 8'd1, 16'hFFFF));
    exp_ack = ~exp_ack; exp_cnt = exp_cnt + 8'd1;
    do_write("tmo_clr_ack", 8'h56, 16'h0001);
    check_value("tmo_clr_resp", resp, resp_word(exp_ack, 1'b0, exp_cnt, 16'hFFFF));
`endif

    // Busy toggling: an even number of changes is a no-op
    wr0 = wr_cnt; rd0 = rd_cnt;
    drive_cmd(1'b0, 8'h40, 16'd0);
    cycles(4);
    check_value("busy_wait_rd", {31'd0, busy}, 32'd1);
    drive_cmd(1'b0, 8'h40, 16'd0); cycles(1);
    drive_cmd(1'b0, 8'h40, 16'd0); cycles(1);
    rd_valid = 1'b1; rd_data = 16'hBEEF;
    cycles(1);
    rd_valid = 1'b0;
    wait_ack("even_ack", 12);
    cycles(8);
    check_value("even_resp", resp, resp_word(exp_ack, 1'b0, exp_cnt, 16'hBEEF));
    check_value("even_strobes", (rd_cnt - rd0) * 16 + (wr_cnt - wr0), 16);

    // Busy toggling: an odd number of changes yields exactly one extra command
    drive_cmd(1'b0, 8'h41, 16'd0);
    cycles(4);
    drive_cmd(1'b1, 8'h77, 16'h1234); cycles(1);
    drive_cmd(1'b1, 8'h77, 16'h1234); cycles(1);
    drive_cmd(1'b1, 8'h77, 16'h1234); cycles(1);
    rd_valid = 1'b1; rd_data = 16'hCAFE;
    cycles(1);
    rd_valid = 1'b0;
    wait_ack("odd_rd_ack", 12);
    check_value("odd_rd_data", {16'd0, resp[15:0]}, 32'h0000_CAFE);
    wait_ack("odd_wr_ack", 12);
    check_value("odd_wr_bus", {last_wr_addr, last_wr_data}, 32'h0077_1234 & 32'h00FF_FFFF);
    cycles(8);
    check_value("odd_strobes", (rd_cnt - rd0) * 16 + (wr_cnt - wr0), 33);
    check_value("odd_resp", resp, resp_word(exp_ack, 1'b0, exp_cnt, 16'hCAFE));

    // Reset in WAIT_RD with the request toggle held
    drive_cmd(1'b0, 8'h34, 16'd0);
    cycles(4);
    check_value("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    cycles(1);
    check_value("mid_rst_resp", resp, 32'd0);
    check_value("mid_rst_outs", {addr, wr_data, wr_en, rd_en, busy}, 32'd0);
    cycles(1);
    rst = 1'b0;
    wr0 = wr_cnt; rd0 = rd_cnt;
    cycles(10);
    check_value("mid_no_spurious", (rd_cnt - rd0) + (wr_cnt - wr0), 0);
    check_value("mid_quiet", {resp[31:1], busy}, 32'd0);
    exp_ack = 1'b0; exp_cnt = 8'd0;
    do_read("mid_next_ack", 8'h34, 16'h1111, 1);
    check_value("mid_next_resp", resp, resp_word(1'b1, 1'b0, 8'd1, 16'h1111));

    // Count wrap over 256 writes from reset
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(3);
    exp_ack = 1'b0; exp_cnt = 8'd0;
    wr0 = wr_cnt;
    for (int i = 0; i < 255; i++) begin
      do_write("wrap_ack", i[7:0], 16'h0F00);
    end
    check_value("wrap_255", resp, resp_word(1'b1, 1'b0, 8'd255, 16'd0));
    do_write("wrap_ack_last", 8'hFF, 16'h0F00);
    check_value("wrap_zero", resp, 32'd0);
    check_value("wrap_pulses", wr_cnt - wr0, 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
